// File: rtl/gcd_requester.sv
// Initiator-side controller for a load/valid GCD core: captures a request, pulses a load,
// waits a bounded number of cycles for the result and returns it on a valid/ready response port.
module gcd_requester #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [WIDTH-1:0] io_req_value1,
    input  logic [WIDTH-1:0] io_req_value2,
    output logic [WIDTH-1:0] io_gcd_value1,
    output logic [WIDTH-1:0] io_gcd_value2,
    output logic             io_gcd_loadingValues,
    input  logic [WIDTH-1:0] io_gcd_outputGCD,
    input  logic             io_gcd_outputValid,
    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [WIDTH-1:0] io_resp_gcd,
    output logic             io_resp_timeout,
    output logic [7:0]       io_resp_cycles,
    output logic             io_busy
);

    // state | meaning
    // IDLE  | ready for a request, operand registers hold last values
    // LOAD  | one-cycle load pulse into the core
    // WAIT  | counting cycles until outputValid or timeout
    // RESP  | response held until consumer accepts
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] v1_q, v1_d;
    logic [WIDTH-1:0] v2_q, v2_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cyc_q, cyc_d;
    logic             to_q, to_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            v1_q    <= '0;
            v2_q    <= '0;
            gcd_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            gcd_q   <= gcd_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        gcd_d   = gcd_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (io_req_valid) begin
                    v1_d = io_req_value1;
                    v2_d = io_req_value2;
                    // GCD(0,b) never terminates in the core, so answer directly
                    if (io_req_value1 == '0) begin
                        gcd_d   = io_req_value2;
                        cyc_d   = '0;
                        to_d    = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (io_gcd_outputValid) begin
                    gcd_d   = io_gcd_outputGCD;
                    cyc_d   = cnt_q;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    gcd_d   = '0;
                    cyc_d   = CNT_LAST;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (io_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_req_ready         = (state_q == IDLE);
        io_busy              = (state_q != IDLE);
        io_gcd_loadingValues = (state_q == LOAD);
        io_resp_valid        = (state_q == RESP);
        io_gcd_value1        = v1_q;
        io_gcd_value2        = v2_q;
        io_resp_gcd          = gcd_q;
        io_resp_timeout      = to_q;
        io_resp_cycles       = cyc_q;
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: subtractive GCD core model or stub behind the DUT,
// transaction-level reference predicting response latency and contents.
module tb_gcd_requester;
    localparam int W = 16;
    localparam int T = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         io_req_valid = 1'b0;
    logic         io_req_ready;
    logic [W-1:0] io_req_value1 = '0;
    logic [W-1:0] io_req_value2 = '0;
    logic [W-1:0] io_gcd_value1, io_gcd_value2;
    logic         io_gcd_loadingValues;
    logic [W-1:0] io_gcd_outputGCD;
    logic         io_gcd_outputValid;
    logic         io_resp_valid;
    logic         io_resp_ready = 1'b0;
    logic [W-1:0] io_resp_gcd;
    logic         io_resp_timeout;
    logic [7:0]   io_resp_cycles;
    logic         io_busy;

    always #5 clock = ~clock;

    gcd_requester #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_value1(io_req_value1), .io_req_value2(io_req_value2),
        .io_gcd_value1(io_gcd_value1), .io_gcd_value2(io_gcd_value2),
        .io_gcd_loadingValues(io_gcd_loadingValues),
        .io_gcd_outputGCD(io_gcd_outputGCD), .io_gcd_outputValid(io_gcd_outputValid),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_gcd(io_resp_gcd), .io_resp_timeout(io_resp_timeout),
        .io_resp_cycles(io_resp_cycles), .io_busy(io_busy)
    );

    // Subtractive GCD core, or a stub the bench drives directly
    logic [W-1:0] cx = '0, cy = '0;
    logic         stub_en = 1'b0, stub_valid = 1'b0;
    logic [W-1:0] stub_gcd = '0;
    always @(posedge clock) begin
        if (io_gcd_loadingValues) begin
            cx <= io_gcd_value1;
            cy <= io_gcd_value2;
        end else if (cx > cy) cx <= cx - cy;
        else cy <= cy - cx;
    end
    assign io_gcd_outputValid = stub_en ? stub_valid : (cy == '0);
    assign io_gcd_outputGCD   = stub_en ? stub_gcd : cx;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of the subtractive algorithm observed over at most T wait cycles
    function automatic void gcd_ref(input int a, input int b, output int g, output int c, output int to);
        int x = a;
        int y = b;
        g = 0; c = T - 1; to = 1;
        for (int k = 0; k < T; k++) begin
            if (y == 0) begin
                g = x; c = k; to = 0;
                break;
            end
            if (x > y) x = x - y;
            else y = y - x;
        end
    endfunction

    // Reference: one outstanding transaction with a predicted response time
    logic chk_en = 1'b0;
    int   inf = 0, n = 0, e_n = 0, e_g = 0, e_c = 0, e_to = 0, e_nz = 0, e_v1 = 0, e_v2 = 0;
    int   ovr_g = 0, ovr_c = 0, ovr_to = 0;
    int   resp_cnt = 0, load_cnt = 0, last_g = 0, last_c = 0, last_to = 0;
    always @(negedge clock) if (chk_en) begin
        int exp_rv;
        exp_rv = (inf != 0 && n >= e_n) ? 1 : 0;
        chk("busy", int'(io_busy), inf);
        chk("req_ready", int'(io_req_ready), inf == 0 ? 1 : 0);
        chk("loadingValues", int'(io_gcd_loadingValues), (inf != 0 && e_nz != 0 && n == 0) ? 1 : 0);
        chk("resp_valid", int'(io_resp_valid), exp_rv);
        chk("gcd_value1", int'(io_gcd_value1), e_v1);
        chk("gcd_value2", int'(io_gcd_value2), e_v2);
        if (exp_rv != 0) begin
            chk("resp_gcd", int'(io_resp_gcd), e_g);
            chk("resp_cycles", int'(io_resp_cycles), e_c);
            chk("resp_timeout", int'(io_resp_timeout), e_to);
        end
        if (io_gcd_loadingValues) load_cnt++;
        if (reset) begin
            inf = 0; e_v1 = 0; e_v2 = 0;
        end else if (inf == 0) begin
            if (io_req_valid) begin
                inf = 1; n = 0;
                e_v1 = int'(io_req_value1); e_v2 = int'(io_req_value2);
                e_nz = (e_v1 != 0) ? 1 : 0;
                if (e_nz == 0) begin
                    e_g = e_v2; e_c = 0; e_to = 0;
                end else if (stub_en) begin
                    e_g = ovr_g; e_c = ovr_c; e_to = ovr_to;
                end else gcd_ref(e_v1, e_v2, e_g, e_c, e_to);
                e_n = (e_nz == 0) ? 0 : e_c + 2;
            end
        end else if (exp_rv != 0 && io_resp_ready) begin
            inf = 0; resp_cnt++;
            last_g = int'(io_resp_gcd); last_c = int'(io_resp_cycles); last_to = int'(io_resp_timeout);
        end else n++;
    end

    logic rr_rand = 1'b0, rr_fixed = 1'b1;
    initial forever begin
        @(posedge clock); #1;
        io_resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic send(input int a, input int b);
        int k = 0;
        io_req_value1 = W'(a); io_req_value2 = W'(b); io_req_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (io_req_ready) break;
            k++;
            if (k > 500) begin
                chk("req_accept_timeout", 0, 1);
                break;
            end
        end
        step();
        io_req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int start = resp_cnt;
        int k = 0;
        while (resp_cnt == start && k < 500) begin
            @(posedge clock); k++;
        end
        if (resp_cnt == start) chk("resp_wait_timeout", 0, 1);
        #1;
    endtask

    initial begin
        int g, c, to, l0, k;
        gcd_ref(60, 48, g, c, to);
        chk("ref_60_48_gcd", g, 12); chk("ref_60_48_cyc", c, 5);
        gcd_ref(21, 14, g, c, to);
        chk("ref_21_14_gcd", g, 7);

        repeat (3) step();
        reset = 1'b0;
        chk("rst_req_ready", int'(io_req_ready), 1);
        chk("rst_resp_valid", int'(io_resp_valid), 0);
        chk("rst_resp_gcd", int'(io_resp_gcd), 0);
        chk("rst_gcd_value1", int'(io_gcd_value1), 0);
        chk_en = 1'b1;

        l0 = load_cnt; send(60, 48); wait_resp();
        chk("t1_loads", load_cnt - l0, 1);
        chk("t1_gcd", last_g, 12); chk("t1_cyc", last_c, 5); chk("t1_to", last_to, 0);

        send(7, 0); wait_resp();
        chk("t2a_gcd", last_g, 7); chk("t2a_cyc", last_c, 0);
        l0 = load_cnt; send(0, 9); wait_resp();
        chk("t2b_loads", load_cnt - l0, 0);
        chk("t2b_gcd", last_g, 9); chk("t2b_cyc", last_c, 0);

        stub_en = 1'b1; stub_valid = 1'b0; ovr_g = 0; ovr_c = T - 1; ovr_to = 1;
        send(5, 3); wait_resp();
        chk("t3_to", last_to, 1); chk("t3_gcd", last_g, 0); chk("t3_cyc", last_c, 63);
        stub_en = 1'b0;

        rr_fixed = 1'b0; send(21, 14);
        k = 0;
        while (!io_resp_valid && k < 200) begin
            @(negedge clock); k++;
        end
        step();
        io_req_value1 = 16'd1; io_req_value2 = 16'd1; io_req_valid = 1'b1;
        repeat (10) step();
        io_req_valid = 1'b0; rr_fixed = 1'b1; wait_resp();
        chk("t4_gcd", last_g, 7);

        send(60, 48); repeat (3) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_busy", int'(io_busy), 0);
        send(9, 6); wait_resp();
        chk("t5_gcd", last_g, 3);

        stub_en = 1'b1; stub_valid = 1'b1; stub_gcd = 16'h0077;
        ovr_g = 16'h55; ovr_c = 3; ovr_to = 0;
        step();
        send(40, 30);
        step(); stub_valid = 1'b0;
        repeat (3) step();
        stub_valid = 1'b1; stub_gcd = 16'h0055;
        wait_resp();
        chk("t6_gcd", last_g, 16'h55); chk("t6_cyc", last_c, 3);
        stub_valid = 1'b0; stub_en = 1'b0;

        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int a, b;
            repeat ($urandom_range(0, 3)) step();
            a = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 120));
            b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 120));
            send(a, b); wait_resp();
        end
        rr_rand = 1'b0;
        repeat (3) step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
